// File: rtl/slurm_reset_seq.sv
// Power-on/system reset sequencer: synchronised hold, then staggered per-domain release; re-sequences on soft request or watchdog timeout.
// Latency: re-sequence request sampled high drops all domains on the next edge; channel k releases HOLD_CYCLES + k*STAGGER_CYCLES after sync exit.
module slurm_reset_seq #(
    parameter int HOLD_CYCLES    = 1000,
    parameter int NUM_CHANNELS   = 2,
    parameter int STAGGER_CYCLES = 10,
    parameter int WDT_CYCLES     = 0
) (
    input  logic                    clk,
    input  logic                    RSTb,
    input  logic                    soft_rst_req,
    input  logic                    wdt_en,
    input  logic                    wdt_kick,
    output logic [NUM_CHANNELS-1:0] rst_out_b,
    output logic [1:0]              rst_cause,
    output logic                    busy
);

    localparam int MAX_HS  = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int MAX_ALL = (MAX_HS > WDT_CYCLES) ? MAX_HS : WDT_CYCLES;
    localparam int CW      = $clog2(MAX_ALL + 1);
    localparam int IW      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_STAGGER = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NUM_CHANNELS-1:0] rst_q, rst_d;
    logic [1:0]              cause_q, cause_d;
    logic                    busy_q, busy_d;
    logic                    sync_q1, sync_q2;
    logic                    timeout;

    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= 1'b1;
            sync_q2 <= sync_q1;
        end
    end

    generate
        if (WDT_CYCLES > 0) begin : g_wdt
            logic [CW-1:0] wdt_cnt_q;
            logic          wdt_run;

            // Soft request outranks a timeout in the same cycle, so it also gates the counter.
            assign wdt_run = sync_q2 && (state_q == S_RUN) && wdt_en && !soft_rst_req;
            assign timeout = wdt_run && !wdt_kick && (wdt_cnt_q == CW'(WDT_CYCLES - 1));

            always_ff @(posedge clk or negedge RSTb) begin
                if (!RSTb) begin
                    wdt_cnt_q <= '0;
                end else if (!wdt_run || wdt_kick || timeout) begin
                    wdt_cnt_q <= '0;
                end else begin
                    wdt_cnt_q <= wdt_cnt_q + 1'b1;
                end
            end
        end else begin : g_no_wdt
            logic unused_wdt;
            assign unused_wdt = wdt_en ^ wdt_kick;
            assign timeout    = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        cause_d = cause_q;
        busy_d  = busy_q;
        if (soft_rst_req || timeout) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '0;
            busy_d  = 1'b1;
            cause_d = soft_rst_req ? 2'b01 : 2'b10;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        rst_d[0] = 1'b1;
                        cnt_d    = '0;
                        if (NUM_CHANNELS == 1) begin
                            state_d = S_RUN;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_STAGGER;
                            idx_d   = IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STAGGER: begin
                    if (cnt_q == CW'(STAGGER_CYCLES - 1)) begin
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            if (IW'(i) == idx_q) begin
                                rst_d[i] = 1'b1;
                            end
                        end
                        cnt_d = '0;
                        if (idx_q == IW'(NUM_CHANNELS - 1)) begin
                            state_d = S_RUN;
                            busy_d  = 1'b0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    busy_d = 1'b0;
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end
    end

    // Until the synchroniser reports release, the sequencer is pinned in its reset image.
    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            cause_q <= 2'b00;
            busy_q  <= 1'b1;
        end else if (!sync_q2) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            cause_q <= 2'b00;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            cause_q <= cause_d;
            busy_q  <= busy_d;
        end
    end

    assign rst_out_b = rst_q;
    assign rst_cause = cause_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_slurm_reset_seq.sv
// Directed bench for slurm_reset_seq: 3-channel sequencer with watchdog, plus a 1-channel no-watchdog instance.
module tb_slurm_reset_seq;

    logic       clk = 1'b0;
    logic       RSTb = 1'b1;
    logic       soft_rst_req = 1'b0;
    logic       wdt_en = 1'b0;
    logic       wdt_kick = 1'b0;
    logic [2:0] rst_out_b;
    logic [1:0] rst_cause;
    logic       busy;

    logic       soft_b = 1'b0;
    logic       wdt_en_b = 1'b1;
    logic       wdt_kick_b = 1'b0;
    logic [0:0] rst_b_out;
    logic [1:0] cause_b;
    logic       busy_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    slurm_reset_seq #(
        .HOLD_CYCLES(16), .NUM_CHANNELS(3), .STAGGER_CYCLES(4), .WDT_CYCLES(32)
    ) dut (
        .clk(clk), .RSTb(RSTb), .soft_rst_req(soft_rst_req), .wdt_en(wdt_en),
        .wdt_kick(wdt_kick), .rst_out_b(rst_out_b), .rst_cause(rst_cause), .busy(busy)
    );

    slurm_reset_seq #(
        .HOLD_CYCLES(16), .NUM_CHANNELS(1), .STAGGER_CYCLES(4), .WDT_CYCLES(0)
    ) dut_single (
        .clk(clk), .RSTb(RSTb), .soft_rst_req(soft_b), .wdt_en(wdt_en_b),
        .wdt_kick(wdt_kick_b), .rst_out_b(rst_b_out), .rst_cause(cause_b), .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected release pattern n edges after the last reset-image edge: 16 / 20 / 24.
    function automatic logic [2:0] exp_rst(input int n);
        return {n >= 24, n >= 20, n >= 16};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (rst_out_b !== 3'b000 || busy !== 1'b1 || rst_cause !== 2'b00) begin
            bad++;
            $display("FAIL por_hold: got rst=%b busy=%b cause=%b expected 000/1/00", rst_out_b, busy, rst_cause);
        end
        RSTb = 1'b1;
        tick();
        total++;
        if (rst_out_b !== 3'b000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL por_sync: got rst=%b busy=%b expected 000/1", rst_out_b, busy);
        end
        tick();
        for (int n = 1; n <= 24; n++) begin
            tick();
            total++;
            if (rst_out_b !== exp_rst(n) || busy !== (n < 24) || rst_b_out !== 1'(n >= 16)) begin
                bad++;
                $display("FAIL por_seq n=%0d: got rst=%b busy=%b single=%b expected %b/%b/%b",
                         n, rst_out_b, busy, rst_b_out, exp_rst(n), (n < 24), (n >= 16));
            end
        end
        total++;
        if (rst_cause !== 2'b00 || cause_b !== 2'b00) begin
            bad++;
            $display("FAIL por_cause: got %b/%b expected 00/00", rst_cause, cause_b);
        end
    endtask

    task automatic test_soft_pulse();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        total++;
        if (rst_out_b !== 3'b000 || busy !== 1'b1 || rst_cause !== 2'b01) begin
            bad++;
            $display("FAIL soft_pulse_assert: got rst=%b busy=%b cause=%b expected 000/1/01", rst_out_b, busy, rst_cause);
        end
        for (int n = 1; n <= 24; n++) begin
            tick();
            total++;
            if (rst_out_b !== exp_rst(n) || busy !== (n < 24)) begin
                bad++;
                $display("FAIL soft_pulse_seq n=%0d: got %b/%b expected %b/%b", n, rst_out_b, busy, exp_rst(n), (n < 24));
            end
        end
    endtask

    task automatic test_soft_hold();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        for (int n = 1; n <= 21; n++) tick();
        total++;
        if (rst_out_b !== 3'b011) begin
            bad++;
            $display("FAIL soft_mid_stagger: got %b expected 011", rst_out_b);
        end
        soft_rst_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (rst_out_b !== 3'b000 || busy !== 1'b1 || rst_cause !== 2'b01) begin
                bad++;
                $display("FAIL soft_hold i=%0d: got rst=%b busy=%b cause=%b expected 000/1/01", i, rst_out_b, busy, rst_cause);
            end
        end
        soft_rst_req = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            tick();
            total++;
            if (rst_out_b !== exp_rst(n) || busy !== (n < 24)) begin
                bad++;
                $display("FAIL soft_hold_seq n=%0d: got %b/%b expected %b/%b", n, rst_out_b, busy, exp_rst(n), (n < 24));
            end
        end
    endtask

    task automatic test_async_mid_stagger();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        for (int n = 1; n <= 18; n++) tick();
        total++;
        if (rst_out_b !== 3'b001) begin
            bad++;
            $display("FAIL async_pre: got %b expected 001", rst_out_b);
        end
        #2;
        RSTb = 1'b0;
        #1;
        total++;
        if (rst_out_b !== 3'b000 || busy !== 1'b1 || rst_cause !== 2'b00) begin
            bad++;
            $display("FAIL async_assert: got rst=%b busy=%b cause=%b expected 000/1/00", rst_out_b, busy, rst_cause);
        end
        tick();
        RSTb = 1'b1;
        tick();
        tick();
        for (int n = 1; n <= 24; n++) begin
            tick();
            total++;
            if (rst_out_b !== exp_rst(n) || busy !== (n < 24)) begin
                bad++;
                $display("FAIL async_seq n=%0d: got %b/%b expected %b/%b", n, rst_out_b, busy, exp_rst(n), (n < 24));
            end
        end
        total++;
        if (rst_cause !== 2'b00) begin
            bad++;
            $display("FAIL async_cause: got %b expected 00", rst_cause);
        end
    endtask

    task automatic test_watchdog_timeout();
        wdt_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            wdt_kick = (i % 20 == 0);
            tick();
            wdt_kick = 1'b0;
            total++;
            if (rst_out_b !== 3'b111) begin
                bad++;
                $display("FAIL wdt_kicked i=%0d: got %b expected 111", i, rst_out_b);
            end
        end
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            tick();
            total++;
            if (rst_out_b !== 3'b111) begin
                bad++;
                $display("FAIL wdt_pre_timeout i=%0d: got %b expected 111", i, rst_out_b);
            end
        end
        tick();
        total++;
        if (rst_out_b !== 3'b000 || busy !== 1'b1 || rst_cause !== 2'b10) begin
            bad++;
            $display("FAIL wdt_timeout: got rst=%b busy=%b cause=%b expected 000/1/10", rst_out_b, busy, rst_cause);
        end
        for (int n = 1; n <= 24; n++) begin
            tick();
            total++;
            if (rst_out_b !== exp_rst(n)) begin
                bad++;
                $display("FAIL wdt_seq n=%0d: got %b expected %b", n, rst_out_b, exp_rst(n));
            end
        end
    endtask

    task automatic test_kick_on_timeout();
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
        for (int i = 1; i <= 31; i++) tick();
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
        total++;
        if (rst_out_b !== 3'b111 || rst_cause !== 2'b10) begin
            bad++;
            $display("FAIL kick_on_timeout: got rst=%b cause=%b expected 111/10", rst_out_b, rst_cause);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= 31; i++) begin
            tick();
            total++;
            if (rst_out_b !== 3'b111) begin
                bad++;
                $display("FAIL simul_pre i=%0d: got %b expected 111", i, rst_out_b);
            end
        end
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        total++;
        if (rst_out_b !== 3'b000 || rst_cause !== 2'b01) begin
            bad++;
            $display("FAIL simul_cause: got rst=%b cause=%b expected 000/01", rst_out_b, rst_cause);
        end
        for (int n = 1; n <= 24; n++) tick();
        wdt_en = 1'b0;
    endtask

    task automatic test_wdt_disabled();
        for (int i = 0; i < 100; i++) begin
            tick();
            total++;
            if (rst_out_b !== 3'b111 || busy !== 1'b0) begin
                bad++;
                $display("FAIL wdt_disabled i=%0d: got rst=%b busy=%b expected 111/0", i, rst_out_b, busy);
            end
        end
    endtask

    task automatic test_single_channel();
        soft_b = 1'b1;
        tick();
        soft_b = 1'b0;
        total++;
        if (rst_b_out !== 1'b0 || busy_b !== 1'b1 || cause_b !== 2'b01) begin
            bad++;
            $display("FAIL single_assert: got rst=%b busy=%b cause=%b expected 0/1/01", rst_b_out, busy_b, cause_b);
        end
        for (int n = 1; n <= 16; n++) begin
            tick();
            total++;
            if (rst_b_out !== 1'(n >= 16) || busy_b !== (n < 16)) begin
                bad++;
                $display("FAIL single_seq n=%0d: got %b/%b expected %b/%b", n, rst_b_out, busy_b, (n >= 16), (n < 16));
            end
        end
        for (int i = 0; i < 60; i++) begin
            tick();
            total++;
            if (rst_b_out !== 1'b1 || busy_b !== 1'b0) begin
                bad++;
                $display("FAIL single_no_wdt i=%0d: got %b/%b expected 1/0", i, rst_b_out, busy_b);
            end
        end
    endtask

    initial begin
        #2;
        RSTb = 1'b0;
        test_reset();
        test_soft_pulse();
        test_soft_hold();
        test_async_mid_stagger();
        test_watchdog_timeout();
        test_kick_on_timeout();
        test_simultaneous();
        test_wdt_disabled();
        test_single_channel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
